// File: rtl/adc733_pkg.sv
// ============================================================================
// Module : adc733_pkg
// Brief  : Shared types, control-word fields and default config table for the
//          adc733 power-up sequencer. Option: ADC733_READBACK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc733_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_WAKE   = 3'd2,
        ST_CFG    = 3'd3,
        ST_GAP    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
`ifdef ADC733_READBACK_EN
        , ST_VERIFY = 3'd7
`endif
    } state_t;

    // Control-word field positions
    localparam int c_bit_ctrl  = 15;
    localparam int c_bit_write = 14;
    localparam int c_addr_msb  = 13;
    localparam int c_addr_lsb  = 11;
    localparam int c_dev_msb   = 10;
    localparam int c_dev_lsb   = 8;
    localparam int c_data_msb  = 7;

    localparam logic [2:0] c_dev_addr = 3'd0;

    localparam logic [2:0] c_reg_a = 3'd0;
    localparam logic [2:0] c_reg_b = 3'd1;
    localparam logic [2:0] c_reg_c = 3'd2;
    localparam logic [2:0] c_reg_d = 3'd3;
    localparam logic [2:0] c_reg_e = 3'd4;

    localparam logic [7:0] c_data_a = 8'h01;
    localparam logic [7:0] c_data_b = 8'h2C;
    localparam logic [7:0] c_data_c = 8'h95;
    localparam logic [7:0] c_data_d = 8'hA7;
    localparam logic [7:0] c_data_e = 8'h3E;

    // Table entries past E are spare slots for N_CFG up to 8 (zero data).
    function automatic logic [15:0] cfg_word(input logic [2:0] idx, input logic wr);
        logic [15:0] w;
        logic [2:0]  addr;
        logic [7:0]  data;
        case (idx)
            3'd0:    begin addr = c_reg_a; data = c_data_a; end
            3'd1:    begin addr = c_reg_b; data = c_data_b; end
            3'd2:    begin addr = c_reg_c; data = c_data_c; end
            3'd3:    begin addr = c_reg_d; data = c_data_d; end
            3'd4:    begin addr = c_reg_e; data = c_data_e; end
            default: begin addr = idx;     data = 8'h00;    end
        endcase
        w                         = '0;
        w[c_bit_ctrl]             = 1'b1;
        w[c_bit_write]            = wr;
        w[c_addr_msb:c_addr_lsb]  = addr;
        w[c_dev_msb:c_dev_lsb]    = c_dev_addr;
        w[c_data_msb:0]           = data;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc733_ctrl_seq_if.sv
// ============================================================================
// Module : adc733_ctrl_seq_if
// Brief  : Control-word handshake between sequencer and framer.
//          Option: ADC733_READBACK_EN adds the readback return path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc733_ctrl_seq_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_word;
`ifdef ADC733_READBACK_EN
    logic        rx_valid;
    logic [15:0] rx_word;
`endif

    modport master (
        output tx_valid,
        output tx_word,
        input  tx_ready
`ifdef ADC733_READBACK_EN
        , input rx_valid
        , input rx_word
`endif
    );

    modport slave (
        input  tx_valid,
        input  tx_word,
        output tx_ready
`ifdef ADC733_READBACK_EN
        , output rx_valid
        , output rx_word
`endif
    );
endinterface

`default_nettype wire

// File: rtl/adc733_cfg_rom.sv
// ============================================================================
// Module : adc733_cfg_rom
// Brief  : Combinational index -> control-word table (write form, plus read
//          form when ADC733_READBACK_EN is defined).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc733_cfg_rom
    import adc733_pkg::*;
(
    input  logic [2:0]  idx_i,
    output logic [15:0] wr_word_o
`ifdef ADC733_READBACK_EN
    , output logic [15:0] rd_word_o
`endif
);

    assign wr_word_o = cfg_word(idx_i, 1'b1);
`ifdef ADC733_READBACK_EN
    assign rd_word_o = cfg_word(idx_i, 1'b0);
`endif

endmodule

`default_nettype wire

// File: rtl/adc733_ctrl_seq.sv
// ============================================================================
// Module : adc733_ctrl_seq
// Brief  : adc733 codec power-up / configuration sequencer with data-mode
//          frame strobes. Option: ADC733_READBACK_EN (verify pass).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc733_ctrl_seq
    import adc733_pkg::*;
#(
    parameter int N_CFG         = 5,
    parameter int RST_CYCLES    = 12,
    parameter int SETTLE_CYCLES = 1200,
    parameter int TMO_CYCLES    = 4095
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               start_i,
    input  logic               sync_i,
    adc733_ctrl_seq_if.master  tx_if,
    output logic               codec_rst_l_o,
    output logic               se_o,
    output logic               frame_go_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int c_max_rs  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int c_cnt_max = (c_max_rs > TMO_CYCLES) ? c_max_rs : TMO_CYCLES;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    localparam logic [c_cw-1:0] c_rst_load    = c_cw'(RST_CYCLES - 1);
    localparam logic [c_cw-1:0] c_settle_load = c_cw'(SETTLE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_tmo_load    = c_cw'(TMO_CYCLES - 1);
    localparam logic [2:0]      c_last_idx    = 3'(N_CFG - 1);

    state_t           state_q, state_d;
    logic [c_cw-1:0]  cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             tx_valid_q, tx_valid_d;
    logic [15:0]      tx_word_q, tx_word_d;
    logic             codec_rst_l_q, codec_rst_l_d;
    logic             se_q, se_d;
    logic             frame_go_q, frame_go_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [15:0]      rom_wr_word;
    logic             cnt_zero;
    logic             xfer;
`ifdef ADC733_READBACK_EN
    logic             vph_q, vph_d;
    logic [15:0]      rom_rd_word;
`endif

    // ROM is addressed with the next index so tx_word lands in step with tx_valid
    adc733_cfg_rom u_rom (
        .idx_i     (idx_d),
        .wr_word_o (rom_wr_word)
`ifdef ADC733_READBACK_EN
        , .rd_word_o (rom_rd_word)
`endif
    );

    assign cnt_zero = (cnt_q == '0);
    assign xfer     = tx_valid_q && tx_if.tx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef ADC733_READBACK_EN
        vph_d   = vph_q;
`endif
        if (start_i) begin
            state_d = ST_RST;
            cnt_d   = c_rst_load;
            idx_d   = '0;
`ifdef ADC733_READBACK_EN
            vph_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_zero) begin
                        state_d = ST_WAKE;
                        cnt_d   = c_settle_load;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (cnt_zero) begin
                        state_d = ST_CFG;
                        idx_d   = '0;
                        cnt_d   = c_tmo_load;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_CFG: begin
                    if (xfer) begin
                        state_d = ST_GAP;
                    end else if (cnt_zero) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (idx_q == c_last_idx) begin
`ifdef ADC733_READBACK_EN
                        state_d = ST_VERIFY;
                        idx_d   = '0;
                        cnt_d   = c_tmo_load;
                        vph_d   = 1'b0;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_CFG;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = c_tmo_load;
                    end
                end
`ifdef ADC733_READBACK_EN
                // Phase 0 issues the read command, phase 1 waits for the reply
                ST_VERIFY: begin
                    if (!vph_q) begin
                        if (xfer) begin
                            vph_d = 1'b1;
                            cnt_d = c_tmo_load;
                        end else if (cnt_zero) begin
                            state_d = ST_ERR;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (tx_if.rx_valid) begin
                        if (tx_if.rx_word[7:0] != tx_word_q[7:0]) begin
                            state_d = ST_ERR;
                        end else if (idx_q == c_last_idx) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            vph_d = 1'b0;
                            cnt_d = c_tmo_load;
                        end
                    end else if (cnt_zero) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                ST_IDLE, ST_RUN, ST_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so every pin is a flop
        tx_valid_d    = (state_d == ST_CFG);
        tx_word_d     = (state_d == ST_CFG) ? rom_wr_word : 16'h0000;
`ifdef ADC733_READBACK_EN
        if (state_d == ST_VERIFY) begin
            tx_valid_d = !vph_d;
            tx_word_d  = rom_rd_word;
        end
`endif
        busy_d        = (state_d == ST_RST) || (state_d == ST_WAKE) ||
                        (state_d == ST_CFG) || (state_d == ST_GAP)
`ifdef ADC733_READBACK_EN
                        || (state_d == ST_VERIFY)
`endif
                        ;
        se_d          = (busy_d && (state_d != ST_RST)) || (state_d == ST_RUN);
        codec_rst_l_d = se_d;
        done_d        = (state_d == ST_RUN);
        err_d         = (state_d == ST_ERR);
        frame_go_d    = sync_i && (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            tx_valid_q    <= 1'b0;
            tx_word_q     <= '0;
            codec_rst_l_q <= 1'b0;
            se_q          <= 1'b0;
            frame_go_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef ADC733_READBACK_EN
            vph_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            tx_valid_q    <= tx_valid_d;
            tx_word_q     <= tx_word_d;
            codec_rst_l_q <= codec_rst_l_d;
            se_q          <= se_d;
            frame_go_q    <= frame_go_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
`ifdef ADC733_READBACK_EN
            vph_q         <= vph_d;
`endif
        end
    end

    assign tx_if.tx_valid = tx_valid_q;
    assign tx_if.tx_word  = tx_word_q;
    assign codec_rst_l_o  = codec_rst_l_q;
    assign se_o           = se_q;
    assign frame_go_o     = frame_go_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_adc733_ctrl_seq.sv
// ============================================================================
// Module : tb_adc733_ctrl_seq
// Brief  : Self-checking bench for adc733_ctrl_seq (default build).
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc733_ctrl_seq;

    localparam int N_CFG = 5, RST_CYCLES = 12, SETTLE_CYCLES = 1200, TMO_CYCLES = 4095;
    localparam int P_IDLE = 0, P_RST = 1, P_WAKE = 2, P_CFG = 3, P_GAP = 4, P_RUN = 5, P_ERR = 6;

    logic clk = 1'b0, rst_l = 1'b0, start = 1'b0, sync = 1'b0;
    logic codec_rst_l, se, frame_go, busy, done, err;

    adc733_ctrl_seq_if bus();

    adc733_ctrl_seq #(
        .N_CFG(N_CFG), .RST_CYCLES(RST_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES), .TMO_CYCLES(TMO_CYCLES)
    ) dut (
        .clk(clk), .rst_l(rst_l), .start_i(start), .sync_i(sync), .tx_if(bus),
        .codec_rst_l_o(codec_rst_l), .se_o(se), .frame_go_o(frame_go),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    logic [15:0] tbl [N_CFG];
    int checks = 0, failures = 0, cyc = 0;
    int m_ph = P_IDLE, m_el = 0, m_idx = 0;
    logic m_fg = 1'b0;
    int ready_mode = 0;
    logic [15:0] q[$];
    int done_cyc = -1, err_cyc = -1, codec_rise = -1, se_rise = -1, first_tx = -1, fg_count = 0;
    logic p_done = 1'b0, p_err = 1'b0, p_codec = 1'b0, p_se = 1'b0, p_txv = 1'b0;
    int k;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock: observe/compare at negedge, drive inputs, advance the model
    task automatic tick(input logic rn, input logic st, input logic sy);
        logic rdy;
        logic [22:0] act, expv;
        cyc++;
        @(negedge clk);
        if (done && !p_done && done_cyc < 0) done_cyc = cyc;
        if (err && !p_err && err_cyc < 0) err_cyc = cyc;
        if (codec_rst_l && !p_codec && codec_rise < 0) codec_rise = cyc;
        if (se && !p_se && se_rise < 0) se_rise = cyc;
        if (bus.tx_valid && !p_txv && first_tx < 0) first_tx = cyc;
        if (frame_go) fg_count++;
        p_done = done; p_err = err; p_codec = codec_rst_l; p_se = se; p_txv = bus.tx_valid;

        expv = {(m_ph >= P_WAKE && m_ph <= P_RUN), (m_ph >= P_WAKE && m_ph <= P_RUN),
                (m_ph == P_CFG), (m_ph >= P_RST && m_ph <= P_GAP), (m_ph == P_RUN),
                (m_ph == P_ERR), m_fg, (m_ph == P_CFG) ? tbl[m_idx] : 16'h0000};
        act  = {codec_rst_l, se, bus.tx_valid, busy, done, err, frame_go, bus.tx_word};
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL outputs at cyc %0d: actual=%h required=%h (codec,se,txv,busy,done,err,fg,word)",
                     cyc, act, expv);
        end

        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            2:       rdy = !(m_ph == P_CFG && m_idx == 2 && m_el < 7);
            default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        if (rn && !st && bus.tx_valid && rdy) q.push_back(bus.tx_word);
        if (rn && st) begin
            q.delete();
            done_cyc = -1; err_cyc = -1; codec_rise = -1; se_rise = -1; first_tx = -1;
        end
        rst_l = rn; start = st; sync = sy; bus.tx_ready = rdy;

        if (!rn) begin
            m_ph = P_IDLE; m_el = 0; m_idx = 0; m_fg = 1'b0;
        end else begin
            m_fg = (m_ph == P_RUN) && !st && sy;
            if (st) begin
                m_ph = P_RST; m_el = 0; m_idx = 0;
            end else begin
                case (m_ph)
                    P_RST:  if (m_el + 1 == RST_CYCLES) begin m_ph = P_WAKE; m_el = 0; end else m_el++;
                    P_WAKE: if (m_el + 1 == SETTLE_CYCLES) begin m_ph = P_CFG; m_el = 0; m_idx = 0; end
                            else m_el++;
                    P_CFG:  if (rdy) m_ph = P_GAP;
                            else if (m_el + 1 == TMO_CYCLES) m_ph = P_ERR;
                            else m_el++;
                    P_GAP:  if (m_idx == N_CFG - 1) m_ph = P_RUN;
                            else begin m_idx++; m_ph = P_CFG; m_el = 0; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tk(input logic st, input logic sy);
        tick(1'b1, st, sy);
    endtask

    task automatic run_to_done(input int bound, input bit rnd_sync);
        for (int i = 0; i < bound && done_cyc < 0; i++)
            tk(1'b0, rnd_sync ? ($urandom_range(0, 5) == 0) : 1'b0);
        check_eq("done_reached", (done_cyc >= 0), 1);
    endtask

    task automatic check_words(input string name);
        check_eq({name, "_count"}, q.size(), N_CFG);
        for (int i = 0; i < q.size() && i < N_CFG; i++)
            check_eq({name, "_word"}, q[i], tbl[i]);
    endtask

    initial begin
        tbl = '{16'hC001, 16'hC82C, 16'hD095, 16'hD8A7, 16'hE03E};
        bus.tx_ready = 1'b0;

        // Reset with start held: must stay idle
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        tk(1'b0, 1'b1);
        tk(1'b0, 1'b0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_codec_rst_l", codec_rst_l, 0);
        check_eq("reset_tx_word", bus.tx_word, 0);

        // Nominal sequence
        ready_mode = 0;
        tk(1'b1, 1'b0); k = cyc;
        tk(1'b0, 1'b0);
        check_eq("start_busy", busy, 1);
        run_to_done(2000, 0);
        check_eq("nominal_done_latency", done_cyc - k, 1223);
        check_eq("codec_rst_low_cycles", codec_rise - k - 1, RST_CYCLES);
        check_eq("se_to_first_tx", first_tx - se_rise, SETTLE_CYCLES);
        check_words("nominal");

        // Data mode: sync every 1800 cycles, then two back-to-back
        fg_count = 0;
        for (int n = 0; n < 3; n++) begin
            repeat (1798) tk(1'b0, 1'b0);
            tk(1'b0, 1'b1);
            tk(1'b0, 1'b0);
            check_eq("frame_go_latency", frame_go, 1);
        end
        tk(1'b0, 1'b1); tk(1'b0, 1'b1); tk(1'b0, 1'b0); tk(1'b0, 1'b0);
        check_eq("frame_go_count", fg_count, 5);

        // Backpressure on word 2
        ready_mode = 2;
        tk(1'b1, 1'b0); k = cyc;
        run_to_done(3000, 0);
        check_eq("bp_done_latency", done_cyc - k, 1230);
        check_words("backpressure");

        // Timeout
        ready_mode = 1;
        tk(1'b1, 1'b0); k = cyc;
        for (int i = 0; i < 6000 && err_cyc < 0; i++) tk(1'b0, 1'b0);
        check_eq("timeout_latency", err_cyc - k, 1 + RST_CYCLES + SETTLE_CYCLES + TMO_CYCLES);
        check_eq("timeout_se", se, 0);
        check_eq("timeout_codec_rst_l", codec_rst_l, 0);
        repeat (4) tk(1'b0, 1'b1);
        check_eq("err_sticky", err, 1);

        // Recovery with random sync during the sequence (must be ignored)
        ready_mode = 0;
        fg_count = 0;
        tk(1'b1, 1'b0); k = cyc;
        tk(1'b0, 1'b0);
        check_eq("start_clears_err", err, 0);
        run_to_done(2000, 1);
        check_eq("recover_done_latency", done_cyc - k, 1223);
        check_eq("no_frame_go_outside_run", fg_count, 0);
        check_words("recover");

        // Restart while word 3 is being offered
        tk(1'b1, 1'b0);
        for (int i = 0; i < 2000 && !(q.size() == 3 && m_ph == P_CFG); i++) tk(1'b0, 1'b0);
        check_eq("reached_word3", q.size(), 3);
        tk(1'b1, 1'b0); k = cyc;
        run_to_done(2000, 0);
        check_eq("restart_done_latency", done_cyc - k, 1223);
        check_words("restart");

        // Randomized ready/sync with random restarts
        ready_mode = 3;
        for (int r = 0; r < 3; r++) begin
            tk(1'b1, 1'b0);
            repeat ($urandom_range(1, 1300)) tk(1'b0, $urandom_range(0, 3) == 0);
        end
        tk(1'b1, 1'b0);
        run_to_done(4000, 1);
        check_words("random");
        check_eq("random_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
